systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
- Parametrised successor to the systolic input controller: accepts one A column vector (ROWS lanes) and one B row vector (COLS lanes) per k-step.
- Applies the triangular skew: lane i is delayed i cycles relative to lane 0.
- Drives the west (A) and north (B) edges of the systolic array with per-lane valid bits.
- Adds tile framing (start / k_len), a ready/valid input handshake with bubble insertion, automatic drain, a done pulse and a synchronous clear.

Parameters:
- DATA_WIDTH, 8, bits per signed element.
- ROWS, 4, A lanes (array rows); >= 1.
- COLS, 4, B lanes (array columns); >= 1.
- K_MAX, 16, maximum k-steps per tile; KW = clog2(K_MAX+1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; highest priority after reset.
- start  in  1  begin tile; sampled only in IDLE.
- k_len  in  KW  k-steps in tile; sampled with start.
- in_valid  in  1  A/B beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- A  in  DATA_WIDTH*ROWS  signed; lane i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- B  in  DATA_WIDTH*COLS  signed; same packing.
- A_out  out  DATA_WIDTH*ROWS  skewed A to array west edge.
- B_out  out  DATA_WIDTH*COLS  skewed B to array north edge.
- a_valid  out  ROWS  per-lane valid of A_out.
- b_valid  out  COLS  per-lane valid of B_out.
- busy  out  1  high in FEED or DRAIN.
- done  out  1  one-cycle pulse with the final element of the tile.

Behaviour:
- Reset (rst_n low, async): state IDLE; all skew registers, A_out, B_out, a_valid, b_valid, busy, done, in_ready and the counters are 0.
- D = max(ROWS, COLS).
- Skew pipeline
  - Lane i of A is a shift chain of depth i+1; lane j of B is a chain of depth j+1.
  - Every stage carries data plus a valid bit.
  - Chains advance every cycle in every state. In IDLE they shift in zeros/invalid, so they self-empty.
  - A beat accepted at edge e appears on A_out lane i (and B_out lane i) during the cycle after edge e+i. Lane 0 latency is 1 cycle.
  - Outputs are fully registered.
  - An invalid stage drives data 0, so the array accumulates nothing on bubbles.
- Bubbles: in FEED with in_valid=0, a zero/invalid slot enters lane 0. Skew alignment between lanes is preserved. The k-count does not advance.
- State machine
  - IDLE: in_ready=0. On start with k_len>0, latch k_len, clear k_cnt, go to FEED. On start with k_len=0, stay IDLE and pulse done the next cycle. Start is ignored outside IDLE.
  - FEED: in_ready=1. Each accept increments k_cnt. On the accept where k_cnt == k_len-1, go to DRAIN (or IDLE if D=1). No further accepts happen.
  - DRAIN: in_ready=0. drain_cnt counts D-1 cycles, then return to IDLE.
- done
  - Asserted for exactly one cycle: the cycle in which the last accepted beat is presented on lane D-1 (the cycle after edge e_last + D-1).
  - The state is IDLE in that cycle, so a new start may be sampled at the end of that cycle.
- A new tile's first beat may enter while the previous tile's tail is still in the chains. No gap is required; lanes are independent.
- k_len > K_MAX: saturate the latched length to K_MAX.
- clear (sync): on the next edge, flush all chains and outputs to 0, return to IDLE, reset counters, and suppress done. It overrides start and any simultaneous accept.
- Reset mid-tile: immediate return to reset values; no done.
- Arithmetic: no arithmetic on data; signed values pass unmodified. Counters are KW bits and cannot wrap because of saturation.

Test Plan:
1. Reset, ROWS=COLS=4, start k_len=3.
   - Stimulus: beats A=(1,2,3,4),(10,20,30,40),(11,22,33,44); B=(5,6,7,8),(50,60,70,80),(55,66,77,88), in_valid held high.
   - Required: A_out lane0 shows 1,10,11 on consecutive cycles; lane3 shows 4,40,44 three cycles later; B_out likewise.
   - Required: in_ready high for exactly 3 cycles; done pulses with lane3=44, b_valid[3]=1.
2. Same tile with in_valid low for one cycle between beats 1 and 2.
   - Required: a bubble (data 0, valid 0) propagates diagonally on all lanes; in_ready stays high 4 cycles; done is one cycle later than in scenario 1.
3. Negative data A=(-1,-128,127,-2).
   - Required: values appear bit-exact on lanes 0..3 with 0..3 cycle offsets.
4. Assert start with k_len=0.
   - Required: in_ready never rises; done pulses next cycle; all valids 0.
5. Assert clear (then, in a separate run, rst_n low) in the cycle after the second accept of a k_len=4 tile.
   - Required: next cycle all A_out/B_out/valid=0, busy=0, done never pulses, in_ready=0.
6. ROWS=2, COLS=5 instance, k_len=2.
   - Required: A lane1 delayed 1 cycle; B lane4 delayed 4 cycles; DRAIN lasts 4 cycles; done aligned with B_out lane4's second beat.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Triangular skew feeder for a systolic array: accepts one A column and one B row per k-step
// and presents them on the west/north edges with lane i delayed i cycles relative to lane 0.

module systolic_skew_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]      vld_q;
    logic [DEPTH-1:0]      vld_d;

    // Shift chain next-state; an empty slot always carries zero data.
    always_comb begin
        vld_d = '0;
        for (int s = 0; s < DEPTH; s++) begin
            data_d[s] = '0;
        end
        if (clear) begin
            vld_d = '0;
        end else begin
            vld_d[0]  = in_valid;
            data_d[0] = in_valid ? in_data : '0;
            for (int s = 1; s < DEPTH; s++) begin
                data_d[s] = data_q[s-1];
                vld_d[s]  = vld_q[s-1];
            end
        end
    end

    // Chain registers; the last stage is the lane output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= data_d[s];
            end
        end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = vld_q[DEPTH-1];

endmodule

module systolic_skew_feeder #(
    parameter  int DATA_WIDTH = 8,
    parameter  int ROWS       = 4,
    parameter  int COLS       = 4,
    parameter  int K_MAX      = 16,
    localparam int KW         = $clog2(K_MAX + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       start,
    input  logic [KW-1:0]              k_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH*ROWS-1:0] A,
    input  logic [DATA_WIDTH*COLS-1:0] B,
    output logic [DATA_WIDTH*ROWS-1:0] A_out,
    output logic [DATA_WIDTH*COLS-1:0] B_out,
    output logic [ROWS-1:0]            a_valid,
    output logic [COLS-1:0]            b_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int D   = (ROWS > COLS) ? ROWS : COLS;
    localparam int DCW = (D > 1) ? $clog2(D) : 1;
    localparam logic [KW-1:0]  K_MAX_W   = KW'(K_MAX);
    localparam logic [KW-1:0]  K_ONE     = KW'(1);
    localparam logic [DCW-1:0] DRAIN_END = DCW'(D - 2);
    localparam logic [DCW-1:0] D_ONE     = DCW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  k_len_q, k_len_d;
    logic [KW-1:0]  k_cnt_q, k_cnt_d;
    logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
    logic           in_ready_q, in_ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           accept_s;

    function automatic logic [KW-1:0] sat_len(input logic [KW-1:0] len);
        if (len > K_MAX_W) begin
            return K_MAX_W;
        end else begin
            return len;
        end
    endfunction

    assign accept_s = in_valid & in_ready_q & ~clear;

    // Tile sequencing: IDLE -> FEED for k_len accepts -> DRAIN for D-1 cycles -> IDLE with done.
    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        k_cnt_d     = k_cnt_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        if (clear) begin
            state_d     = S_IDLE;
            k_len_d     = '0;
            k_cnt_d     = '0;
            drain_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && (k_len == '0)) begin
                        done_d = 1'b1;
                    end else if (start) begin
                        k_len_d = sat_len(k_len);
                        k_cnt_d = '0;
                        state_d = S_FEED;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FEED: begin
                    if (accept_s) begin
                        k_cnt_d = k_cnt_q + K_ONE;
                        if (k_cnt_q == (k_len_q - K_ONE)) begin
                            drain_cnt_d = '0;
                            if (D == 1) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = S_DRAIN;
                            end
                        end else begin
                            state_d = S_FEED;
                        end
                    end else begin
                        state_d = S_FEED;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q == DRAIN_END) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q + D_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        in_ready_d = (state_d == S_FEED);
        busy_d     = (state_d != S_IDLE);
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_len_q     <= '0;
            k_cnt_q     <= '0;
            drain_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            k_cnt_q     <= k_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

    for (genvar i = 0; i < ROWS; i++) begin : g_a_lane
        systolic_skew_lane #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(i + 1)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear),
            .in_valid (accept_s),
            .in_data  (A[i*DATA_WIDTH +: DATA_WIDTH]),
            .out_valid(a_valid[i]),
            .out_data (A_out[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_lane
        systolic_skew_lane #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(j + 1)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear),
            .in_valid (accept_s),
            .in_data  (B[j*DATA_WIDTH +: DATA_WIDTH]),
            .out_valid(b_valid[j]),
            .out_data (B_out[j*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: a 4x4 and a 2x5 instance, with per-lane expected beats and done
// pulses queued with their due cycle and compared on every falling edge.

module tb_systolic_skew_feeder;

    logic clk = 1'b0;
    logic rst_n, clear;

    logic        start0, in_valid0, in_ready0, busy0, done0;
    logic [4:0]  k_len0;
    logic [31:0] A0, B0, A_out0, B_out0;
    logic [3:0]  a_valid0, b_valid0;

    logic        start1, in_valid1, in_ready1, busy1, done1;
    logic [4:0]  k_len1;
    logic [15:0] A1, A_out1;
    logic [39:0] B1, B_out1;
    logic [1:0]  a_valid1;
    logic [4:0]  b_valid1;

    typedef struct {
        int         inst;
        int         side;   // 0 = A lane, 1 = B lane, 2 = done
        int         lane;
        int         cyc;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rdy0_cnt = 0;
    int   busy1_cnt = 0;

    systolic_skew_feeder #(.DATA_WIDTH(8), .ROWS(4), .COLS(4), .K_MAX(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start0), .k_len(k_len0),
        .in_valid(in_valid0), .in_ready(in_ready0), .A(A0), .B(B0),
        .A_out(A_out0), .B_out(B_out0), .a_valid(a_valid0), .b_valid(b_valid0),
        .busy(busy0), .done(done0)
    );

    systolic_skew_feeder #(.DATA_WIDTH(8), .ROWS(2), .COLS(5), .K_MAX(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start1), .k_len(k_len1),
        .in_valid(in_valid1), .in_ready(in_ready1), .A(A1), .B(B1),
        .A_out(A_out1), .B_out(B_out1), .a_valid(a_valid1), .b_valid(b_valid1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int find_due(input int inst, input int side, input int lane);
        foreach (sb[k]) begin
            if (sb[k].inst == inst && sb[k].side == side && sb[k].lane == lane && sb[k].cyc == cyc)
                return k;
        end
        return -1;
    endfunction

    task automatic mon_lane(input int inst, input int side, input int lane,
                            input logic v, input logic [7:0] d);
        int    k;
        string tag;
        k   = find_due(inst, side, lane);
        tag = $sformatf("u%0d_%s%0d_c%0d", inst, (side == 0) ? "a" : "b", lane, cyc);
        chk({tag, "_valid"}, 64'(v), 64'(k >= 0));
        if (k >= 0) begin
            if (v) chk({tag, "_data"}, 64'(d), 64'(sb[k].data));
            sb.delete(k);
        end else begin
            chk({tag, "_bubble_data"}, 64'(d), 64'd0);
        end
    endtask

    task automatic mon_done(input int inst, input logic v);
        int k;
        k = find_due(inst, 2, 0);
        chk($sformatf("u%0d_done_c%0d", inst, cyc), 64'(v), 64'(k >= 0));
        if (k >= 0) sb.delete(k);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            mon_lane(0, 0, i, a_valid0[i], A_out0[i*8 +: 8]);
            mon_lane(0, 1, i, b_valid0[i], B_out0[i*8 +: 8]);
        end
        for (int i = 0; i < 2; i++) mon_lane(1, 0, i, a_valid1[i], A_out1[i*8 +: 8]);
        for (int j = 0; j < 5; j++) mon_lane(1, 1, j, b_valid1[j], B_out1[j*8 +: 8]);
        mon_done(0, done0);
        mon_done(1, done1);
        if (in_ready0) rdy0_cnt++;
        if (busy1) busy1_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input int inst, input int nr, input int nc,
                             input logic [39:0] a, input logic [39:0] b);
        for (int i = 0; i < nr; i++) sb.push_back('{inst, 0, i, cyc + 1 + i, a[i*8 +: 8]});
        for (int j = 0; j < nc; j++) sb.push_back('{inst, 1, j, cyc + 1 + j, b[j*8 +: 8]});
    endtask

    task automatic push_done(input int inst, input int offset);
        sb.push_back('{inst, 2, 0, cyc + offset, 8'h00});
    endtask

    task automatic flush_from(input int from_cyc);
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].cyc >= from_cyc) sb.delete(k);
        end
    endtask

    task automatic beat0(input logic [31:0] a, input logic [31:0] b);
        in_valid0 = 1'b1;
        A0 = a;
        B0 = b;
        push_beat(0, 4, 4, {8'h00, a}, {8'h00, b});
    endtask

    task automatic chk_quiet0(input string tag);
        chk({tag, "_A_out"},   64'(A_out0),   64'd0);
        chk({tag, "_B_out"},   64'(B_out0),   64'd0);
        chk({tag, "_a_valid"}, 64'(a_valid0), 64'd0);
        chk({tag, "_b_valid"}, 64'(b_valid0), 64'd0);
        chk({tag, "_busy"},    64'(busy0),    64'd0);
        chk({tag, "_in_ready"},64'(in_ready0),64'd0);
        chk({tag, "_done"},    64'(done0),    64'd0);
    endtask

    initial begin
        int r;
        rst_n = 1'b0; clear = 1'b0;
        start0 = 1'b0; k_len0 = 5'd0; in_valid0 = 1'b0; A0 = 32'd0; B0 = 32'd0;
        start1 = 1'b0; k_len1 = 5'd0; in_valid1 = 1'b0; A1 = 16'd0; B1 = 40'd0;
        repeat (3) tick();
        chk_quiet0("reset");
        chk("reset_u1_busy", 64'(busy1), 64'd0);
        rst_n = 1'b1;
        tick();

        // Scenario 1: k_len=3, back-to-back beats.
        r = rdy0_cnt;
        start0 = 1'b1; k_len0 = 5'd3;
        tick();
        start0 = 1'b0;
        chk("s1_in_ready_feed", 64'(in_ready0), 64'd1);
        chk("s1_busy_feed", 64'(busy0), 64'd1);
        beat0(32'h04030201, 32'h08070605); tick();
        beat0(32'h281E140A, 32'h50463C32); tick();
        beat0(32'h2C21160B, 32'h584D4237); push_done(0, 4); tick();
        in_valid0 = 1'b0;
        chk("s1_in_ready_drain", 64'(in_ready0), 64'd0);
        chk("s1_busy_drain", 64'(busy0), 64'd1);
        repeat (3) tick();
        chk("s1_busy_done_cycle", 64'(busy0), 64'd0);
        tick();
        chk("s1_ready_cycles", 64'(rdy0_cnt - r), 64'd3);

        // Scenario 2: same tile with one bubble between beats 1 and 2.
        r = rdy0_cnt;
        start0 = 1'b1; k_len0 = 5'd3;
        tick();
        start0 = 1'b0;
        beat0(32'h04030201, 32'h08070605); tick();
        in_valid0 = 1'b0; A0 = 32'hDEADBEEF; B0 = 32'hCAFEF00D; tick();
        beat0(32'h281E140A, 32'h50463C32); tick();
        beat0(32'h2C21160B, 32'h584D4237); push_done(0, 4); tick();
        in_valid0 = 1'b0;
        repeat (3) tick();
        chk("s2_ready_cycles", 64'(rdy0_cnt - r), 64'd4);

        // Scenario 3: negative data, started in the done cycle of the previous tile.
        start0 = 1'b1; k_len0 = 5'd1;
        tick();
        start0 = 1'b0;
        beat0(32'hFE7F80FF, 32'h009C64FB); push_done(0, 4); tick();
        in_valid0 = 1'b0;
        repeat (4) tick();

        // Scenario 4: zero-length tile.
        r = rdy0_cnt;
        start0 = 1'b1; k_len0 = 5'd0; push_done(0, 1);
        tick();
        start0 = 1'b0;
        chk("s4_busy", 64'(busy0), 64'd0);
        repeat (4) tick();
        chk("s4_ready_cycles", 64'(rdy0_cnt - r), 64'd0);

        // Saturation: k_len=31 is limited to 16 beats; the 17th offered beat is refused.
        r = rdy0_cnt;
        start0 = 1'b1; k_len0 = 5'd31;
        tick();
        start0 = 1'b0;
        for (int b = 0; b < 17; b++) begin
            in_valid0 = 1'b1;
            A0 = {8'(b*4 + 4), 8'(b*4 + 3), 8'(b*4 + 2), 8'(b*4 + 1)};
            B0 = {8'(b*4 + 103), 8'(b*4 + 102), 8'(b*4 + 101), 8'(b*4 + 100)};
            if (b < 16) push_beat(0, 4, 4, {8'h00, A0}, {8'h00, B0});
            if (b == 15) push_done(0, 4);
            tick();
        end
        in_valid0 = 1'b0;
        chk("sat_ready_cycles", 64'(rdy0_cnt - r), 64'd16);
        repeat (4) tick();

        // Scenario 5a: clear in the cycle after the second accept, with start and a beat offered.
        start0 = 1'b1; k_len0 = 5'd4;
        tick();
        start0 = 1'b0;
        beat0(32'h14131211, 32'h24232221); tick();
        beat0(32'h18171615, 32'h28272625); tick();
        clear = 1'b1; start0 = 1'b1; k_len0 = 5'd2;
        beat0(32'h1C1B1A19, 32'h2C2B2A29);
        flush_from(cyc + 1);
        tick();
        clear = 1'b0; start0 = 1'b0; in_valid0 = 1'b0;
        chk_quiet0("s5_clear");
        repeat (6) tick();

        // Scenario 5b: asynchronous reset at the same point.
        start0 = 1'b1; k_len0 = 5'd4;
        tick();
        start0 = 1'b0;
        beat0(32'h34333231, 32'h44434241); tick();
        beat0(32'h38373635, 32'h48474645); tick();
        in_valid0 = 1'b0;
        rst_n = 1'b0;
        flush_from(cyc);
        #1;
        chk_quiet0("s5_reset");
        tick();
        rst_n = 1'b1;
        repeat (6) tick();

        // Scenario 6: 2x5 instance, k_len=2; DRAIN spans 4 cycles.
        r = busy1_cnt;
        start1 = 1'b1; k_len1 = 5'd2;
        tick();
        start1 = 1'b0;
        chk("s6_in_ready", 64'(in_ready1), 64'd1);
        in_valid1 = 1'b1; A1 = 16'h0201; B1 = 40'h0F0E0D0C0B;
        push_beat(1, 2, 5, {24'h0, A1}, B1); tick();
        A1 = 16'hF2F1; B1 = 40'h8584838281;
        push_beat(1, 2, 5, {24'h0, A1}, B1); push_done(1, 5); tick();
        in_valid1 = 1'b0;
        chk("s6_in_ready_drain", 64'(in_ready1), 64'd0);
        repeat (4) tick();
        chk("s6_busy_done_cycle", 64'(busy1), 64'd0);
        tick();
        chk("s6_busy_cycles", 64'(busy1_cnt - r), 64'd6);

        repeat (3) tick();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
